// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding/hazard scoreboard.
package fwd_pkg;

  // Widest register address an entry can hold; narrower REG_AW values are zero-extended.
  localparam int RD_MAX_W = 8;

  // Select value meaning "read from the register file, no bypass".
  localparam int SEL_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                is_load;
  } entry_t;

  // Select must encode 0 (regfile) through depth (oldest tracked stage).
  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority match of one ID source register against all in-flight writers.
// The youngest matching writer (lowest stage index) determines both the
// bypass distance and whether the value is a load that is not yet available.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_AVAIL = 2,
  parameter int SELW       = 2
) (
  input  entry_t [DEPTH:1] entries,
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  output logic [SELW-1:0]   sel,
  output logic              load_hit
);

  // Scan oldest to youngest so the youngest match is the last to assign.
  always_comb begin
    sel      = SELW'(SEL_RF);
    load_hit = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (used && (src != '0) && entries[k].valid &&
          (entries[k].rd == RD_MAX_W'(src))) begin
        sel      = SELW'(k);
        load_hit = entries[k].is_load && (k < LOAD_AVAIL);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard for the 5-stage core. Tracks register writers
// in the DEPTH stages after ID, produces per-source bypass distances and a
// load-use stall, and registers the selects into EX.
// Optional macro HAZARD_STATS_EN adds a 32-bit stall-cycle counter;
// without it stall_cnt is tied to zero and no counter flops exist.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int  REG_AW     = 5,
  parameter int  NUM_SRC    = 3,
  parameter int  DEPTH      = 3,
  parameter int  LOAD_AVAIL = 2,
  localparam int SELW       = sel_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     advance,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic                     id_reg_write,
  input  logic                     id_mem_to_reg,
  input  logic [REG_AW-1:0]        id_rd,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  output logic                     stall,
  output logic [NUM_SRC*SELW-1:0]  fwd_sel,
  output logic [NUM_SRC*SELW-1:0]  fwd_sel_q,
  output logic [31:0]              stall_cnt
);

  if (REG_AW > RD_MAX_W) begin : g_bad_aw
    $error("REG_AW exceeds entry rd width");
  end

  entry_t [DEPTH:1]   entries;
  entry_t             new_entry;
  logic [NUM_SRC-1:0] load_hit;
  logic               insert;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match #(
      .REG_AW     (REG_AW),
      .DEPTH      (DEPTH),
      .LOAD_AVAIL (LOAD_AVAIL),
      .SELW       (SELW)
    ) u_match (
      .entries  (entries),
      .src      (id_src[i*REG_AW +: REG_AW]),
      .used     (id_src_used[i]),
      .sel      (fwd_sel[i*SELW +: SELW]),
      .load_hit (load_hit[i])
    );
  end

  assign stall  = id_valid && !flush && (|load_hit);
  assign insert = id_valid && id_reg_write && (id_rd != '0) && !stall && !flush;

  // Entry loaded into stage 1 on advance: the ID writer, or a bubble.
  always_comb begin
    new_entry = '0;
    if (insert) begin
      new_entry.valid   = 1'b1;
      new_entry.rd      = RD_MAX_W'(id_rd);
      new_entry.is_load = id_mem_to_reg;
    end
  end

  // Writer shift register and the EX-stage select register.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries   <= '0;
      fwd_sel_q <= '0;
    end else begin
      if (advance) begin
        for (int k = DEPTH; k >= 2; k--) begin
          entries[k] <= entries[k-1];
        end
        entries[1] <= new_entry;
      end else if (flush) begin
        entries[1] <= '0;
      end

      if (flush) begin
        fwd_sel_q <= '0;
      end else if (advance) begin
        fwd_sel_q <= (id_valid && !stall) ? fwd_sel : '0;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] cnt;

  // Counts cycles in which a load-use stall actually inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (stall && advance) begin
      cnt <= cnt + 32'd1;
    end
  end

  assign stall_cnt = cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed hazard scenarios with
// hand-derived expectations queued as stimulus is applied and compared when
// the outputs are sampled.
module tb_fwd_scoreboard;

`ifdef HAZARD_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        advance;
  logic        flush;
  logic        id_valid;
  logic        id_reg_write;
  logic        id_mem_to_reg;
  logic [4:0]  id_rd;
  logic [14:0] id_src;
  logic [2:0]  id_src_used;
  logic        stall;
  logic [5:0]  fwd_sel;
  logic [5:0]  fwd_sel_q;
  logic [31:0] stall_cnt;

  fwd_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .advance       (advance),
    .flush         (flush),
    .id_valid      (id_valid),
    .id_reg_write  (id_reg_write),
    .id_mem_to_reg (id_mem_to_reg),
    .id_rd         (id_rd),
    .id_src        (id_src),
    .id_src_used   (id_src_used),
    .stall         (stall),
    .fwd_sel       (fwd_sel),
    .fwd_sel_q     (fwd_sel_q),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;   // 0 stall, 1 fwd_sel, 2 fwd_sel_q, 3 stall_cnt
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ex(input string tag, input int kind, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Compare every queued expectation against the current outputs.
  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        0:       obs = {31'b0, stall};
        1:       obs = {26'b0, fwd_sel};
        2:       obs = {26'b0, fwd_sel_q};
        default: obs = stall_cnt;
      endcase
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input logic rw, input logic ld, input logic [4:0] rd,
                        input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [2:0] used);
    id_valid      = v;
    id_reg_write  = rw;
    id_mem_to_reg = ld;
    id_rd         = rd;
    id_src        = {s2, s1, s0};
    id_src_used   = used;
  endtask

  task automatic idle();
    set_id(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000);
  endtask

  task automatic reset_dut();
    rst     = 1'b1;
    advance = 1'b1;
    flush   = 1'b0;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; advance = 1'b1; flush = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Reset state: empty scoreboard, even with sources requested.
    set_id(1, 1, 0, 5'd3, 5'd3, 5'd3, 5'd3, 3'b111);
    ex("rst_stall", 0, 0); ex("rst_sel", 1, 0); ex("rst_selq", 2, 0); ex("rst_cnt", 3, 0);
    drain();

    // 1: add $3 then sub using $3 -> EX/MEM bypass.
    reset_dut();
    set_id(1, 1, 0, 5'd3, 5'd1, 5'd2, 5'd0, 3'b011);
    ex("t1_add_stall", 0, 0);
    drain();
    tick();
    set_id(1, 1, 0, 5'd9, 5'd3, 5'd4, 5'd0, 3'b011);
    ex("t1_sel", 1, 6'b000001); ex("t1_stall", 0, 0); ex("t1_selq_pre", 2, 0);
    drain();
    tick();
    idle();
    ex("t1_selq", 2, 6'b000001);
    drain();
    tick();
    set_id(1, 0, 0, 5'd0, 5'd3, 5'd9, 5'd0, 3'b011);
    ex("t1_selq_bubble", 2, 0); ex("t1_sel_wb_mem", 1, 6'b001011);
    drain();

    // 2: lw $5 then add using $5 -> one stall with bubble, then MEM/WB bypass.
    reset_dut();
    set_id(1, 1, 1, 5'd5, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    set_id(1, 1, 0, 5'd6, 5'd1, 5'd5, 5'd0, 3'b011);
    ex("t2_stall", 0, 1); ex("t2_sel_k1", 1, 6'b000100);
    drain();
    tick();
    ex("t2_stall_clr", 0, 0); ex("t2_sel_k2", 1, 6'b001000); ex("t2_selq_bubble", 2, 0);
    ex("t2_cnt", 3, (STATS != 0) ? 32'd1 : 32'd0);
    drain();
    tick();
    idle();
    ex("t2_selq", 2, 6'b001000);
    drain();

    // 3: youngest writer wins over an older load of the same register.
    reset_dut();
    set_id(1, 1, 1, 5'd7, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    set_id(1, 1, 0, 5'd10, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    set_id(1, 1, 0, 5'd7, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    set_id(1, 0, 0, 5'd0, 5'd7, 5'd10, 5'd0, 3'b011);
    ex("t3_sel", 1, 6'b001001); ex("t3_stall", 0, 0);
    drain();

    // 3b: younger load over an older ALU writer still stalls; flush masks it.
    reset_dut();
    set_id(1, 1, 0, 5'd7, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    set_id(1, 1, 1, 5'd7, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    set_id(1, 0, 0, 5'd0, 5'd7, 5'd0, 5'd0, 3'b001);
    ex("t3b_sel", 1, 6'b000001); ex("t3b_stall", 0, 1);
    drain();
    flush = 1'b1;
    ex("t3b_flush_stall", 0, 0);
    drain();
    flush = 1'b0;

    // 4: store-data forwarded from a load two stages ahead.
    reset_dut();
    set_id(1, 1, 1, 5'd8, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    set_id(1, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    set_id(1, 0, 0, 5'd0, 5'd1, 5'd0, 5'd8, 3'b101);
    ex("t4_sel", 1, 6'b100000); ex("t4_stall", 0, 0);
    drain();

    // 4b: a load to $0 is never tracked, so $0 readers never bypass or stall.
    reset_dut();
    set_id(1, 1, 1, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    set_id(1, 0, 0, 5'd0, 5'd1, 5'd0, 5'd0, 3'b101);
    ex("t4b_sel_k1", 1, 0); ex("t4b_stall", 0, 0);
    drain();
    tick();
    ex("t4b_sel_k2", 1, 0);
    drain();

    // 5: flush while frozen clears entry1 only and zeroes fwd_sel_q.
    reset_dut();
    set_id(1, 1, 0, 5'd11, 5'd0, 5'd0, 5'd0, 3'b000);
    tick();
    set_id(1, 1, 0, 5'd12, 5'd11, 5'd0, 5'd0, 3'b001);
    ex("t5_sel_pre", 1, 6'b000001);
    drain();
    tick();
    set_id(1, 1, 0, 5'd13, 5'd12, 5'd11, 5'd0, 3'b011);
    ex("t5_selq_pre", 2, 6'b000001);
    drain();
    flush = 1'b1; advance = 1'b0;
    ex("t5_flush_sel", 1, 6'b001001); ex("t5_flush_stall", 0, 0);
    drain();
    tick();
    flush = 1'b0;
    ex("t5_post_sel", 1, 6'b001000); ex("t5_post_selq", 2, 0);
    drain();
    tick();
    ex("t5_hold_sel", 1, 6'b001000); ex("t5_hold_selq", 2, 0);
    drain();
    advance = 1'b1;
    tick();
    idle();
    ex("t5_adv_selq", 2, 6'b001000);
    drain();

    // 6: three load-use stalls (one frozen cycle not counted), then reset.
    reset_dut();
    for (int n = 0; n < 3; n++) begin
      set_id(1, 1, 1, 5'd5, 5'd0, 5'd0, 5'd0, 3'b000);
      tick();
      set_id(1, 1, 0, 5'd6, 5'd0, 5'd5, 5'd0, 3'b010);
      ex("t6_stall", 0, 1);
      drain();
      if (n == 0) begin
        advance = 1'b0;
        tick();
        ex("t6_frozen_stall", 0, 1); ex("t6_frozen_cnt", 3, 0);
        drain();
        advance = 1'b1;
      end
      tick();
      ex("t6_stall_clr", 0, 0);
      drain();
      tick();
    end
    set_id(1, 0, 0, 5'd0, 5'd6, 5'd5, 5'd0, 3'b011);
    ex("t6_cnt", 3, (STATS != 0) ? 32'd3 : 32'd0); ex("t6_sel_pre_rst", 1, 6'b001101);
    drain();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ex("t6_cnt_rst", 3, 0); ex("t6_sel_rst", 1, 0); ex("t6_stall_rst", 0, 0);
    ex("t6_selq_rst", 2, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
